hgc_vga_out: RTL and testbench

Output stage between the HGC core (`video`, `intensity`, `hsync`, `vsync`) and the VGA DAC pins (`red`, `green`, `blue`, `vga_hsync`, `vga_vsync`). It regenerates a clean blanking window from the sync edges and delays sync to match the video pipeline. It tracks line-length stability so the picture only appears once timing is locked, and maps mono pixels to a switch-selected green, amber or white palette. Replaces the direct `video`/`intensity`→RGB mapping in the 70 Hz top level.

---
 rtl/hgc_pkg.sv | 45 ++++
 rtl/hgc_vga_out_if.sv | 27 ++
 rtl/hgc_sync_tracker.sv | 106 ++++++++++
 rtl/hgc_vga_out.sv | 80 ++++++++
 tb/tb_hgc_vga_out.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/hgc_pkg.sv
// Shared constants for the HGC VGA output stage: counter widths, palette indices,
// DAC levels per palette and the lock FSM state type.
package hgc_pkg;

    localparam int unsigned HCNT_W  = 11;
    localparam int unsigned VCNT_W  = 10;
    localparam int unsigned MATCH_W = 3;
    localparam int unsigned R_W     = 6;
    localparam int unsigned G_W     = 7;
    localparam int unsigned B_W     = 6;

    localparam logic [1:0] PAL_GREEN = 2'd0;
    localparam logic [1:0] PAL_AMBER = 2'd1;
    localparam logic [1:0] PAL_WHITE = 2'd2;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

    localparam rgb_t GREEN_NORM  = '{r: 6'd0,  g: 7'd84,  b: 6'd0};
    localparam rgb_t GREEN_BRITE = '{r: 6'd0,  g: 7'd127, b: 6'd0};
    localparam rgb_t AMBER_NORM  = '{r: 6'd42, g: 7'd64,  b: 6'd0};
    localparam rgb_t AMBER_BRITE = '{r: 6'd63, g: 7'd96,  b: 6'd0};
    localparam rgb_t WHITE_NORM  = '{r: 6'd42, g: 7'd84,  b: 6'd42};
    localparam rgb_t WHITE_BRITE = '{r: 6'd63, g: 7'd127, b: 6'd63};

    typedef enum logic {
        StUnlocked,
        StLocked
    } lock_state_e;

    // Index 3 is treated as white as well.
    function automatic rgb_t pal_level(logic [1:0] pal, logic bright);
        rgb_t lvl;
        case (pal)
            PAL_GREEN: lvl = bright ? GREEN_BRITE : GREEN_NORM;
            PAL_AMBER: lvl = bright ? AMBER_BRITE : AMBER_NORM;
            default:   lvl = bright ? WHITE_BRITE : WHITE_NORM;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/hgc_vga_out_if.sv
// Signal bundle between the HGC core side and the VGA output stage.
interface hgc_vga_out_if;
    import hgc_pkg::*;

    logic           video;
    logic           intensity;
    logic           hsync;
    logic           vsync;
    logic [1:0]     pal_sel;
    logic [R_W-1:0] red;
    logic [G_W-1:0] green;
    logic [B_W-1:0] blue;
    logic           vga_hsync;
    logic           vga_vsync;
    logic           locked;

    modport master (
        output video, intensity, hsync, vsync, pal_sel,
        input  red, green, blue, vga_hsync, vga_vsync, locked
    );

    modport slave (
        input  video, intensity, hsync, vsync, pal_sel,
        output red, green, blue, vga_hsync, vga_vsync, locked
    );

endinterface

// File: rtl/hgc_sync_tracker.sv
// Sync edge detection, horizontal/vertical position counters, active window decode
// and the line-length lock FSM. Inputs are the stage-1 registered syncs.
module hgc_sync_tracker
    import hgc_pkg::*;
#(
    parameter logic [HCNT_W-1:0]  H_BACK     = 11'd40,
    parameter logic [HCNT_W-1:0]  H_ACTIVE   = 11'd720,
    parameter logic [VCNT_W-1:0]  V_BACK     = 10'd20,
    parameter logic [VCNT_W-1:0]  V_ACTIVE   = 10'd348,
    parameter logic [MATCH_W-1:0] LOCK_LINES = 3'd4
) (
    input  logic clk,
    input  logic busreset,
    input  logic hsync,
    input  logic vsync,
    output logic h_act,
    output logic v_act,
    output logic locked,
    output logic vsync_fall
);

    logic               hsync_prev, vsync_prev;
    logic               hsync_fall;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d, line_len_q;
    logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    lock_state_e        state_q, state_d;
    logic               hcnt_sat, len_eq;

    assign hsync_fall = hsync_prev & ~hsync;
    assign vsync_fall = vsync_prev & ~vsync;
    assign hcnt_sat   = &hcnt_q;
    assign len_eq     = (hcnt_q == line_len_q);

    always_comb begin
        hcnt_d = hcnt_sat ? hcnt_q : hcnt_q + 1'b1;
        if (hsync_fall) begin
            hcnt_d = '0;
        end
        vcnt_d = vcnt_q;
        if (vsync_fall) begin
            vcnt_d = '0;
        end else if (hsync_fall && !(&vcnt_q)) begin
            vcnt_d = vcnt_q + 1'b1;
        end
        match_d = match_q;
        if (hsync_fall) begin
            if (!len_eq) begin
                match_d = '0;
            end else if (match_q != LOCK_LINES) begin
                match_d = match_q + 1'b1;
            end
        end
    end

    // A saturated hcnt means hsync has gone away; it overrides any lock decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StUnlocked: begin
                if (!hcnt_sat && hsync_fall && match_d == LOCK_LINES) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (hcnt_sat || (hsync_fall && !len_eq)) begin
                    state_d = StUnlocked;
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    always_ff @(posedge clk) begin
        if (busreset) begin
            hsync_prev <= 1'b0;
            vsync_prev <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            line_len_q <= '0;
            match_q    <= '0;
            state_q    <= StUnlocked;
        end else begin
            hsync_prev <= hsync;
            vsync_prev <= vsync;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            match_q    <= match_d;
            state_q    <= state_d;
            if (hsync_fall) begin
                line_len_q <= hcnt_q;
            end
        end
    end

    // One extra bit so the window upper bounds cannot wrap.
    logic [HCNT_W:0] h_hi;
    logic [VCNT_W:0] v_hi;

    assign h_hi   = {1'b0, H_BACK} + {1'b0, H_ACTIVE};
    assign v_hi   = {1'b0, V_BACK} + {1'b0, V_ACTIVE};
    assign h_act  = ({1'b0, hcnt_q} >= {1'b0, H_BACK}) && ({1'b0, hcnt_q} < h_hi);
    assign v_act  = ({1'b0, vcnt_q} >= {1'b0, V_BACK}) && ({1'b0, vcnt_q} < v_hi);
    assign locked = (state_q == StLocked);

endmodule

// File: rtl/hgc_vga_out.sv
// HGC to VGA DAC output stage: two-register pipeline, frame-synchronous palette
// register and mono-to-RGB level mux, blanked until line timing is locked.
module hgc_vga_out
    import hgc_pkg::*;
#(
    parameter logic [HCNT_W-1:0]  H_BACK     = 11'd40,
    parameter logic [HCNT_W-1:0]  H_ACTIVE   = 11'd720,
    parameter logic [VCNT_W-1:0]  V_BACK     = 10'd20,
    parameter logic [VCNT_W-1:0]  V_ACTIVE   = 10'd348,
    parameter logic [MATCH_W-1:0] LOCK_LINES = 3'd4
) (
    input logic          clk,
    input logic          busreset,
    hgc_vga_out_if.slave bus
);

    logic       video_q, intensity_q, hsync_q, vsync_q;
    logic [1:0] pal_q;
    logic       h_act, v_act, locked, vsync_fall;
    rgb_t       pix;
    rgb_t       rgb_q;
    logic       vga_hsync_q, vga_vsync_q;

    hgc_sync_tracker #(
        .H_BACK     (H_BACK),
        .H_ACTIVE   (H_ACTIVE),
        .V_BACK     (V_BACK),
        .V_ACTIVE   (V_ACTIVE),
        .LOCK_LINES (LOCK_LINES)
    ) u_sync_tracker (
        .clk        (clk),
        .busreset   (busreset),
        .hsync      (hsync_q),
        .vsync      (vsync_q),
        .h_act      (h_act),
        .v_act      (v_act),
        .locked     (locked),
        .vsync_fall (vsync_fall)
    );

    always_comb begin
        pix = '0;
        if (video_q && h_act && v_act && locked) begin
            pix = pal_level(pal_q, intensity_q);
        end
    end

    always_ff @(posedge clk) begin
        if (busreset) begin
            video_q     <= 1'b0;
            intensity_q <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            pal_q       <= PAL_GREEN;
            rgb_q       <= '0;
            vga_hsync_q <= 1'b0;
            vga_vsync_q <= 1'b0;
        end else begin
            video_q     <= bus.video;
            intensity_q <= bus.intensity;
            hsync_q     <= bus.hsync;
            vsync_q     <= bus.vsync;
            rgb_q       <= pix;
            vga_hsync_q <= hsync_q;
            vga_vsync_q <= vsync_q;
            // Palette only changes at frame start to avoid mid-frame tearing.
            if (vsync_fall) begin
                pal_q <= bus.pal_sel;
            end
        end
    end

    assign bus.red       = rgb_q.r;
    assign bus.green     = rgb_q.g;
    assign bus.blue      = rgb_q.b;
    assign bus.vga_hsync = vga_hsync_q;
    assign bus.vga_vsync = vga_vsync_q;
    assign bus.locked    = locked;

endmodule

// File: tb/tb_hgc_vga_out.sv
// Randomized bench for hgc_vga_out against a position-based reference model of
// the blanking window, line-length lock and palette behaviour.
module tb_hgc_vga_out;

    logic       clk;
    logic       busreset;
    logic [1:0] pal_sel_drv;

    hgc_vga_out_if bus ();

    hgc_vga_out dut (
        .clk      (clk),
        .busreset (busreset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;

    // DAC levels [palette][bright][r,g,b]
    int unsigned lv [3][2][3] = '{
        '{'{0, 84, 0},   '{0, 127, 0}},
        '{'{42, 64, 0},  '{63, 96, 0}},
        '{'{42, 84, 42}, '{63, 127, 63}}
    };

    // Reference model: what the DUT must show in the current cycle.
    int unsigned cyc;
    int unsigned line_start;
    int unsigned line_no;
    int unsigned m_pal;
    int unsigned lens [$];
    bit          s_h, s_v, s_vid, s_int, p_h, p_v, m_lk;
    int unsigned exp_r, exp_g, exp_b, exp_hs, exp_vs, exp_lk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Advance the model across one clock edge with the inputs sampled at that edge.
    task automatic model_edge(input bit rst, input bit vid, input bit inten, input bit hs,
                              input bit vs, input bit [1:0] pal);
        int unsigned hc;
        bit          hf, vf, win;
        int          run;
        if (rst) begin
            line_start = cyc + 1;
            line_no    = 0;
            lens       = {};
            lens.push_back(0);
            m_lk  = 0;
            m_pal = 0;
            s_h = 0; s_v = 0; s_vid = 0; s_int = 0; p_h = 0; p_v = 0;
            exp_r = 0; exp_g = 0; exp_b = 0; exp_hs = 0; exp_vs = 0; exp_lk = 0;
        end else begin
            hc = cyc - line_start;
            if (hc > 2047) hc = 2047;
            hf  = p_h && !s_h;
            vf  = p_v && !s_v;
            win = m_lk && hc >= 40 && hc < 760 && line_no >= 20 && line_no < 368;
            exp_r  = (win && s_vid) ? lv[m_pal][s_int][0] : 0;
            exp_g  = (win && s_vid) ? lv[m_pal][s_int][1] : 0;
            exp_b  = (win && s_vid) ? lv[m_pal][s_int][2] : 0;
            exp_hs = s_h;
            exp_vs = s_v;
            run = 0;
            if (hf) begin
                lens.push_back(hc);
                if (lens.size() > 8) void'(lens.pop_front());
                for (int i = lens.size() - 1; i > 0; i--) begin
                    if (lens[i] != lens[i-1]) break;
                    run++;
                end
            end
            if (hc == 2047) m_lk = 0;
            else if (hf) m_lk = m_lk ? (run > 0) : (run >= 4);
            exp_lk = m_lk;
            if (hf) line_start = cyc + 1;
            if (vf) line_no = 0;
            else if (hf && line_no < 1023) line_no++;
            if (vf) m_pal = (pal > 2) ? 2 : pal;
            p_h = s_h; p_v = s_v;
            s_h = hs; s_v = vs; s_vid = vid; s_int = inten;
        end
        cyc++;
    endtask

    task automatic step(input bit rst, input bit hs, input bit vs);
        bit vid, inten;
        @(negedge clk);
        check_eq("red", bus.red, exp_r);
        check_eq("green", bus.green, exp_g);
        check_eq("blue", bus.blue, exp_b);
        check_eq("vga_hsync", bus.vga_hsync, exp_hs);
        check_eq("vga_vsync", bus.vga_vsync, exp_vs);
        check_eq("locked", bus.locked, exp_lk);
        vid   = ($urandom_range(0, 3) != 0);
        inten = 1'($urandom_range(0, 1));
        busreset      = rst;
        bus.video     = vid;
        bus.intensity = inten;
        bus.hsync     = hs;
        bus.vsync     = vs;
        bus.pal_sel   = pal_sel_drv;
        model_edge(rst, vid, inten, hs, vs, pal_sel_drv);
    endtask

    // vsync takes vs_a during the hsync pulse and vs_b after it.
    task automatic drive_line(input int len, input int hsw, input bit vs_a, input bit vs_b);
        for (int i = 0; i < len; i++) begin
            step(1'b0, i < hsw, (i < hsw) ? vs_a : vs_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    initial begin
        bit vs_a, vs_b;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        pal_sel_drv   = 2'd1;
        busreset      = 1'b1;
        bus.video     = 1'b0;
        bus.intensity = 1'b0;
        bus.hsync     = 1'b0;
        bus.vsync     = 1'b0;
        bus.pal_sel   = pal_sel_drv;
        model_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pal_sel_drv);
        step(1'b1, 1'b0, 1'b0);

        // 910-clock lines: amber frame with one 911 glitch, pal_sel to white mid-frame,
        // then a white frame. vsync falls together with hsync on lines 3 and 28.
        for (int g = 0; g < 51; g++) begin
            if (g == 24) pal_sel_drv = 2'd2;
            vs_a = (g <= 3) || (g >= 26 && g <= 28);
            vs_b = (g < 3) || (g == 26) || (g == 27);
            drive_line((g == 9) ? 911 : 910, 80, vs_a, vs_b);
            if (g == 7)  check_eq("lock_acquired", bus.locked, 1);
            if (g == 10) check_eq("lock_lost_911", bus.locked, 0);
            if (g == 16) check_eq("lock_regained", bus.locked, 1);
        end

        // Mid-line reset, then a full green frame of short lines for the vertical edges.
        pal_sel_drv = 2'd0;
        for (int i = 0; i < 30; i++) step(1'b0, i < 16, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("rst_locked", bus.locked, 0);
        check_eq("rst_green", bus.green, 0);
        check_eq("rst_vga_hsync", bus.vga_hsync, 0);
        for (int l = 0; l < 374; l++) begin
            drive_line(80, 16, l <= 3, l < 3);
            if (l == 30) check_eq("lock_short_lines", bus.locked, 1);
        end

        // hsync stops; vsync keeps toggling.
        for (int i = 0; i < 2300; i++) step(1'b0, 1'b0, (i % 400) < 100);
        check_eq("sync_loss_unlock", bus.locked, 0);
        step(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
